// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: MMIO offsets, lane
// patterns, region decode and the lane-shape check for store enables.
package dmem_resp_pkg;

  // MMIO register offsets from the MMIO base address
  localparam logic [31:0] DMEM_MMIO_CNT    = 32'h0000_0000;
  localparam logic [31:0] DMEM_MMIO_TOHOST = 32'h0000_0004;

  // Unshifted byte-lane patterns for each access size
  localparam logic [3:0] DM_BYTE     = 4'b0001;
  localparam logic [3:0] DM_HALFWORD = 4'b0011;
  localparam logic [3:0] DM_WORD     = 4'b1111;

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_CNT    = 2'd1,
    REG_TOHOST = 2'd2,
    REG_NONE   = 2'd3
  } region_e;

  // Classify a byte address; MMIO registers decode on the word address.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] mmio_base,
                                            input logic [31:0] ram_bytes);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    if (addr < ram_bytes)
      return REG_RAM;
    else if (waddr == mmio_base + DMEM_MMIO_CNT)
      return REG_CNT;
    else if (waddr == mmio_base + DMEM_MMIO_TOHOST)
      return REG_TOHOST;
    else
      return REG_NONE;
  endfunction

  // Enables must start at the address offset and run contiguously upward
  // (a pattern truncated at lane 3 still counts as contiguous here).
  function automatic logic lane_shape_ok(input logic [3:0] wea,
                                         input logic [1:0] off);
    logic [3:0] rel;
    logic       below;
    rel   = wea >> off;
    below = (wea & ~(DM_WORD << off)) != 4'b0000;
    return !below && ((rel == DM_BYTE) || (rel == DM_HALFWORD) ||
                      (rel == (DM_WORD >> 1)) || (rel == DM_WORD));
  endfunction

endpackage

// File: rtl/dmem_resp_lane_merge.sv
// Aligns one slot's store data to its byte offset, overlays the enabled
// lanes on a base word, and flags stores that cannot land intact.
module dmem_lane_merge
  import dmem_resp_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [3:0]  wea,
  output logic [31:0] merged,
  output logic [31:0] aligned,
  output logic        misalign
);

  logic [63:0] wide;

  // Store data arrives zero-extended in the low bits; any nonzero bits that
  // the offset pushes past lane 3 mean the access straddles the word.
  always_comb begin
    wide     = {32'h0, wdata} << {off, 3'b000};
    aligned  = wide[31:0];
    merged   = base;
    for (int i = 0; i < 4; i++) begin
      if (wea[i]) merged[8*i +: 8] = aligned[8*i +: 8];
    end
    misalign = (wea != 4'b0000) &&
               (!lane_shape_ok(wea, off) || (wide[63:32] != 32'h0));
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for two parallel memory slots: same-cycle reads,
// byte-enabled writes at posedge, older-to-younger forwarding, and an MMIO
// window holding a cycle counter and a sticky tohost/end register.
// The RAM is indexed by address bits only, so DEPTH must be a power of two.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_num,
  input  logic        a_we,
  input  logic [3:0]  a_wea,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  input  logic        b_num,
  input  logic        b_we,
  input  logic [3:0]  b_wea,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        end_sign,
  output logic [31:0] tohost_val,
  output logic        err
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];
  logic [31:0] cnt_q, tohost_q;
  logic        end_q, err_q;

  // Slots are handled by role: o_* is the older slot, y_* the younger.
  logic             a_older;
  logic             o_we, y_we, o_wr, y_wr;
  logic [3:0]       o_wea, y_wea, o_wea_g, y_wea_g;
  logic [31:0]      o_addr, y_addr, o_wdata, y_wdata;
  region_e          o_reg, y_reg;
  logic [IDX_W-1:0] o_idx, y_idx;
  logic [31:0]      o_word, y_word, y_base;
  logic [31:0]      o_merged, y_merged, o_aligned, y_aligned;
  logic             o_mis, y_mis;
  logic             o_ram_wr, y_ram_wr, same_word, collide;
  logic [31:0]      o_rdata, y_rdata;
  logic             err_set;

  function automatic logic [31:0] read_mux(input region_e     r,
                                           input logic [31:0] ram_word,
                                           input logic [31:0] cnt,
                                           input logic [31:0] th);
    case (r)
      REG_RAM:    return ram_word;
      REG_CNT:    return cnt;
      REG_TOHOST: return th;
      default:    return 32'h0;
    endcase
  endfunction

  // Order the slots (A wins ties), decode regions and fetch array words.
  always_comb begin
    a_older = ~a_num | b_num;
    if (a_older) begin
      o_we = a_we; o_wea = a_wea; o_addr = a_addr; o_wdata = a_wdata;
      y_we = b_we; y_wea = b_wea; y_addr = b_addr; y_wdata = b_wdata;
    end else begin
      o_we = b_we; o_wea = b_wea; o_addr = b_addr; o_wdata = b_wdata;
      y_we = a_we; y_wea = a_wea; y_addr = a_addr; y_wdata = a_wdata;
    end
    o_wea_g  = o_we ? o_wea : 4'b0000;
    y_wea_g  = y_we ? y_wea : 4'b0000;
    o_wr     = o_wea_g != 4'b0000;
    y_wr     = y_wea_g != 4'b0000;
    o_reg    = decode_region(o_addr, MMIO_BASE, RAM_BYTES);
    y_reg    = decode_region(y_addr, MMIO_BASE, RAM_BYTES);
    o_idx    = o_addr[IDX_W+1:2];
    y_idx    = y_addr[IDX_W+1:2];
    o_word   = mem[o_idx];
    y_word   = mem[y_idx];
    o_ram_wr = o_wr && (o_reg == REG_RAM);
    y_ram_wr = y_wr && (y_reg == REG_RAM);
  end

  dmem_lane_merge u_merge_old (
    .base     (o_word),
    .wdata    (o_wdata),
    .off      (o_addr[1:0]),
    .wea      (o_wea_g),
    .merged   (o_merged),
    .aligned  (o_aligned),
    .misalign (o_mis)
  );

  // The younger slot sees the older store's result when they share a word;
  // this one word serves both as forwarded read data and collision base.
  always_comb begin
    same_word = o_ram_wr && (y_reg == REG_RAM) && (o_idx == y_idx);
    collide   = same_word && y_ram_wr;
    y_base    = same_word ? o_merged : y_word;
  end

  dmem_lane_merge u_merge_yng (
    .base     (y_base),
    .wdata    (y_wdata),
    .off      (y_addr[1:0]),
    .wea      (y_wea_g),
    .merged   (y_merged),
    .aligned  (y_aligned),
    .misalign (y_mis)
  );

  // Read data back to the physical slots, and error detection on writes.
  always_comb begin
    o_rdata = read_mux(o_reg, o_word, cnt_q, tohost_q);
    y_rdata = read_mux(y_reg, y_base, cnt_q, tohost_q);
    a_rdata = a_older ? o_rdata : y_rdata;
    b_rdata = a_older ? y_rdata : o_rdata;
    err_set = (o_wr && (o_mis || (o_reg == REG_CNT) || (o_reg == REG_NONE))) ||
              (y_wr && (y_mis || (y_reg == REG_CNT) || (y_reg == REG_NONE)));
  end

  // RAM commit; on a same-word collision only the younger's merged word lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (o_ram_wr && !collide) mem[o_idx] <= o_merged;
      if (y_ram_wr)             mem[y_idx] <= y_merged;
    end
  end

  // Cycle counter (frozen after end), tohost with younger priority, sticky err.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 32'h0;
      tohost_q <= 32'h0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (!end_q) cnt_q <= cnt_q + 32'h1;
      if (y_wr && (y_reg == REG_TOHOST)) begin
        tohost_q <= y_aligned;
        end_q    <= 1'b1;
      end else if (o_wr && (o_reg == REG_TOHOST)) begin
        tohost_q <= o_aligned;
        end_q    <= 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign end_sign   = end_q;
  assign tohost_val = tohost_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus randomized
// two-slot traffic compared against a byte-addressed reference memory.
module tb_dmem_resp;

  localparam logic [31:0] MMIO = 32'h0001_0000;
  localparam logic [31:0] IDLE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_num = 1'b0, a_we = 1'b0, b_num = 1'b0, b_we = 1'b0;
  logic [3:0]  a_wea = 4'h0, b_wea = 4'h0;
  logic [31:0] a_addr = 32'h0, a_wdata = 32'h0, b_addr = 32'h0, b_wdata = 32'h0;
  logic [31:0] a_rdata, b_rdata, tohost_val;
  logic        end_sign, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    int          w;
    logic [31:0] addr;
    logic [31:0] data;
    logic        num;
    logic [3:0]  wea;
  } op_t;

  logic [7:0]  ref_b [int];
  logic [31:0] ra, rb, c1, c2, cw, ce;

  dmem_resp dut (
    .clk(clk), .rst(rst),
    .a_num(a_num), .a_we(a_we), .a_wea(a_wea), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_num(b_num), .b_we(b_we), .b_wea(b_wea), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rdata(b_rdata),
    .end_sign(end_sign), .tohost_val(tohost_val), .err(err)
  );

  // Clock
  always #5 clk = ~clk;

  // Operation builders: a store of w bytes, value zero-extended in low bits
  function automatic op_t st(int w, logic [31:0] addr, logic [31:0] data, logic num);
    op_t o;
    logic [3:0] m;
    m      = (w == 1) ? 4'b0001 : (w == 2) ? 4'b0011 : 4'b1111;
    o.we   = 1'b1;
    o.w    = w;
    o.addr = addr;
    o.num  = num;
    o.wea  = m << addr[1:0];
    o.data = (w == 4) ? data : (data & ((32'h1 << (8 * w)) - 32'h1));
    return o;
  endfunction

  // A read leaves we low but puts junk on wea, which must be ignored.
  function automatic op_t rd(logic [31:0] addr, logic num);
    op_t o;
    o.we   = 1'b0;
    o.w    = 0;
    o.addr = addr;
    o.num  = num;
    o.wea  = 4'($urandom_range(0, 15));
    o.data = $urandom;
    return o;
  endfunction

  function automatic op_t rand_op();
    int          kind = int'($urandom_range(0, 3));
    logic [31:0] base = 32'h100 + 32'(4 * $urandom_range(0, 7));
    logic        num  = 1'($urandom_range(0, 1));
    logic [31:0] d    = $urandom;
    case (kind)
      0:       return rd(base + 32'($urandom_range(0, 3)), num);
      1:       return st(1, base + 32'($urandom_range(0, 3)), d, num);
      2:       return st(2, base + 32'(2 * $urandom_range(0, 1)), d, num);
      default: return st(4, base, d, num);
    endcase
  endfunction

  // Reference memory: bytes land from addr upward, clipped at the word end.
  function automatic bit known(logic [31:0] addr);
    int b = int'({addr[31:2], 2'b00});
    return ref_b.exists(b) && ref_b.exists(b + 1) && ref_b.exists(b + 2) && ref_b.exists(b + 3);
  endfunction

  function automatic logic [31:0] model_word(logic [31:0] addr);
    int b = int'({addr[31:2], 2'b00});
    return {ref_b[b + 3], ref_b[b + 2], ref_b[b + 1], ref_b[b]};
  endfunction

  task automatic model_store(input op_t o);
    if (o.we && (o.addr < 32'h4000)) begin
      for (int k = 0; k < o.w; k++) begin
        if (int'(o.addr[1:0]) + k < 4) ref_b[int'(o.addr) + k] = o.data[8*k +: 8];
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RAM words are checked when known, unmapped reads must be zero, MMIO
  // values are checked by the directed steps.
  task automatic check_read(input string tag, input logic [31:0] addr, input logic [31:0] obs);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    if (addr < 32'h4000) begin
      if (known(addr)) check(tag, obs, model_word(addr));
    end else if ((w != MMIO) && (w != MMIO + 32'h4)) begin
      check(tag, obs, 32'h0);
    end
  endtask

  // Driver: one cycle; older slot reads pre-state, younger sees older store.
  task automatic step(input op_t a, input op_t b, output logic [31:0] oa, output logic [31:0] ob);
    logic a_old;
    @(negedge clk);
    a_num = a.num; a_we = a.we; a_wea = a.wea; a_addr = a.addr; a_wdata = a.data;
    b_num = b.num; b_we = b.we; b_wea = b.wea; b_addr = b.addr; b_wdata = b.data;
    #2;
    oa = a_rdata;
    ob = b_rdata;
    a_old = !(a.num && !b.num);
    if (a_old) begin
      check_read("rd_a_old", a.addr, oa);
      model_store(a);
      check_read("rd_b_yng", b.addr, ob);
      model_store(b);
    end else begin
      check_read("rd_b_old", b.addr, ob);
      model_store(b);
      check_read("rd_a_yng", a.addr, oa);
      model_store(a);
    end
  endtask

  // Reset for one edge, optionally with writes that must be dropped.
  task automatic do_reset(input bit with_writes);
    @(negedge clk);
    rst = 1'b1;
    a_num = 1'b0; a_we = with_writes; a_wea = 4'hF; a_addr = 32'h10; a_wdata = 32'h5555_5555;
    b_num = 1'b1; b_we = with_writes; b_wea = 4'hF; b_addr = MMIO + 32'h4; b_wdata = 32'h7;
    @(negedge clk);
    rst = 1'b0;
    a_we = 1'b0; a_addr = MMIO;
    b_we = 1'b0; b_addr = 32'h10;
    #2;
    check("rst_cnt", a_rdata, 32'h0);
    check("rst_end", {31'h0, end_sign}, 32'h0);
    check("rst_tohost", tohost_val, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check_read("rst_ram", 32'h10, b_rdata);
  endtask

  initial begin
    do_reset(1'b0);

    // Seed words later used as "old" contents
    step(st(4, 32'h20, 32'h2020_2020, 1'b0), st(4, 32'h30, 32'h3030_3030, 1'b1), ra, rb);

    // Word store then read back
    step(st(4, 32'h10, 32'h1122_3344, 1'b0), rd(IDLE, 1'b1), ra, rb);
    step(rd(32'h10, 1'b0), rd(IDLE, 1'b1), ra, rb);
    check("sw_rd", ra, 32'h1122_3344);
    check("sw_err", {31'h0, err}, 32'h0);

    // Byte store by younger A; older B reads the pre-store word
    step(st(1, 32'h13, 32'hAB, 1'b1), rd(32'h10, 1'b0), ra, rb);
    check("sb_old_b", rb, 32'h1122_3344);
    step(rd(32'h10, 1'b0), rd(IDLE, 1'b1), ra, rb);
    check("sb_word", ra, 32'hAB22_3344);

    // Forwarding from older A to younger B
    step(st(4, 32'h20, 32'hDEAD_BEEF, 1'b0), rd(32'h20, 1'b1), ra, rb);
    check("fwd_b", rb, 32'hDEAD_BEEF);
    check("fwd_a_old", ra, 32'h2020_2020);

    // Collision: younger A half over older B word
    step(st(2, 32'h30, 32'hCAFE, 1'b1), st(4, 32'h30, 32'h0102_0304, 1'b0), ra, rb);
    step(rd(32'h30, 1'b0), rd(IDLE, 1'b1), ra, rb);
    check("collide", ra, 32'h0102_CAFE);

    // Randomized traffic on a small window to provoke forwarding/collisions
    for (int i = 0; i < 8; i++)
      step(st(4, 32'h100 + 32'(4 * i), $urandom, 1'b0), rd(IDLE, 1'b1), ra, rb);
    for (int i = 0; i < 300; i++)
      step(rand_op(), rand_op(), ra, rb);
    for (int i = 0; i < 8; i++)
      step(rd(32'h100 + 32'(4 * i), 1'b0), rd(32'h100 + 32'(4 * i), 1'b1), ra, rb);
    check("rand_err", {31'h0, err}, 32'h0);

    // Counter advances one per cycle
    step(rd(MMIO, 1'b0), rd(IDLE, 1'b1), c1, rb);
    for (int i = 0; i < 4; i++) step(rd(IDLE, 1'b0), rd(IDLE, 1'b1), ra, rb);
    step(rd(MMIO, 1'b0), rd(IDLE, 1'b1), c2, rb);
    check("cnt_delta", c2 - c1, 32'd5);

    // tohost write ends the run and freezes the counter
    step(st(4, MMIO + 32'h4, 32'h1, 1'b0), rd(MMIO, 1'b1), ra, cw);
    step(rd(MMIO + 32'h4, 1'b0), rd(MMIO, 1'b1), ra, ce);
    check("tohost_rd", ra, 32'h1);
    check("tohost_val", tohost_val, 32'h1);
    check("end_sign", {31'h0, end_sign}, 32'h1);
    check("cnt_last", ce, cw + 32'h1);
    step(rd(IDLE, 1'b0), rd(IDLE, 1'b1), ra, rb);
    step(rd(IDLE, 1'b0), rd(IDLE, 1'b1), ra, rb);
    step(rd(IDLE, 1'b0), rd(MMIO, 1'b1), ra, rb);
    check("cnt_frozen", rb, ce);
    check("tohost_err", {31'h0, err}, 32'h0);

    // Half at offset 3: only lane 3 lands, err set
    step(st(2, 32'h33, 32'hCAFE, 1'b0), rd(IDLE, 1'b1), ra, rb);
    step(rd(32'h30, 1'b0), rd(IDLE, 1'b1), ra, rb);
    check("mis_word", ra, 32'hFE02_CAFE);
    check("mis_err", {31'h0, err}, 32'h1);

    // Reset clears MMIO state and drops the writes presented with it
    do_reset(1'b1);
    step(rd(32'h10, 1'b0), rd(IDLE, 1'b1), ra, rb);
    check("rst_drop_wr", ra, 32'hAB22_3344);

    // Store to the read-only counter is ignored and flags err
    step(st(4, MMIO, 32'h1234, 1'b0), rd(IDLE, 1'b1), ra, rb);
    step(rd(IDLE, 1'b0), rd(MMIO, 1'b1), ra, rb);
    check("cnt_ro", rb, 32'd3);
    check("cnt_wr_err", {31'h0, err}, 32'h1);

    // Store to an unmapped address flags err
    do_reset(1'b0);
    step(st(4, 32'h8000, 32'h1, 1'b0), rd(IDLE, 1'b1), ra, rb);
    step(rd(IDLE, 1'b0), rd(IDLE, 1'b1), ra, rb);
    check("unmap_err", {31'h0, err}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
